// File: rtl/wb_slave_pkg.sv
// Shared constants and helpers for the Wishbone control/status register slave:
// register offsets, default ID, window size and byte-lane helpers.
`timescale 1ns/1ps
package wb_slave_pkg;

    localparam logic [4:0] REG_ID       = 5'h00;
    localparam logic [4:0] REG_SCRATCH  = 5'h04;
    localparam logic [4:0] REG_CTRL     = 5'h08;
    localparam logic [4:0] REG_STATUS   = 5'h0C;
    localparam logic [4:0] REG_IRQ_PEND = 5'h10;
    localparam logic [4:0] REG_IRQ_MASK = 5'h14;
    localparam logic [4:0] REG_CYCLE    = 5'h18;
    localparam logic [4:0] REG_ERRCNT   = 5'h1C;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5A11_0001;
    localparam logic [31:0] WINDOW_BYTES     = 32'd32;

    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

    function automatic logic is_read_only(input logic [4:0] off);
        return (off == REG_ID) || (off == REG_STATUS) ||
               (off == REG_CYCLE) || (off == REG_ERRCNT);
    endfunction

endpackage

// File: rtl/event_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector with a registered
// one-cycle pulse; the synchronized level is also exported for plain status use.
`timescale 1ns/1ps
module event_sync_edge #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;
    logic [W-1:0] rise_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
            rise_q <= '0;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign o_sync = sync_q;
    assign o_rise = rise_q;

endmodule

// File: rtl/wb_reg_slave.sv
// Wishbone classic slave with a 32-byte control/status register window.
// Every accepted access gets exactly one registered ack or err pulse.
`timescale 1ns/1ps
module wb_reg_slave
    import wb_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE  = ID_VALUE_DEFAULT,
    parameter int          EVENT_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [31:0]        s_wb_adr_i,
    input  logic [31:0]        s_wb_dat_i,
    output logic [31:0]        s_wb_dat_o,
    input  logic               s_wb_we_i,
    input  logic [3:0]         s_wb_sel_i,
    input  logic               s_wb_stb_i,
    input  logic               s_wb_cyc_i,
    output logic               s_wb_ack_o,
    output logic               s_wb_err_o,
    input  logic [31:0]        i_status,
    input  logic [EVENT_W-1:0] i_event,
    output logic [31:0]        o_ctrl,
    output logic               o_irq
);

    logic [31:0]        status_sync;
    logic [31:0]        status_rise_unused;
    logic [EVENT_W-1:0] event_sync_unused;
    logic [EVENT_W-1:0] event_rise;

    event_sync_edge #(.W(32)) u_status_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_status),
        .o_sync  (status_sync),
        .o_rise  (status_rise_unused)
    );

    event_sync_edge #(.W(EVENT_W)) u_event_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_event),
        .o_sync  (event_sync_unused),
        .o_rise  (event_rise)
    );

    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        dat_q, dat_d;
    logic [31:0]        scratch_q, scratch_d;
    logic [31:0]        ctrl_q, ctrl_d;
    logic [31:0]        mask_q, mask_d;
    logic [EVENT_W-1:0] pend_q, pend_d;
    logic [31:0]        cycle_q, cycle_d;
    logic [31:0]        errcnt_q, errcnt_d;

    // Subtracting the base first keeps the window check correct for any BASE_ADDR.
    logic [31:0]        offset;
    logic [4:0]         reg_off;
    logic               in_window;
    logic               access_bad;
    logic               accept;
    logic               do_write;
    logic [31:0]        wmask;
    logic [31:0]        rdata;
    logic [31:0]        pend_ext;
    logic [EVENT_W-1:0] w1c_bits;

    assign offset     = s_wb_adr_i - BASE_ADDR;
    assign reg_off    = offset[4:0];
    assign in_window  = offset < WINDOW_BYTES;
    assign access_bad = ~in_window | (|s_wb_adr_i[1:0]) |
                        (s_wb_we_i & is_read_only(reg_off));
    assign accept     = s_wb_cyc_i & s_wb_stb_i & ~ack_q & ~err_q;
    assign do_write   = accept & ~access_bad & s_wb_we_i;
    assign wmask      = sel_to_mask(s_wb_sel_i);

    always_comb begin
        pend_ext = '0;
        pend_ext[EVENT_W-1:0] = pend_q;
    end

    always_comb begin
        rdata = '0;
        case (reg_off)
            REG_ID:       rdata = ID_VALUE;
            REG_SCRATCH:  rdata = scratch_q;
            REG_CTRL:     rdata = ctrl_q;
            REG_STATUS:   rdata = status_sync;
            REG_IRQ_PEND: rdata = pend_ext;
            REG_IRQ_MASK: rdata = mask_q;
            REG_CYCLE:    rdata = cycle_q;
            REG_ERRCNT:   rdata = errcnt_q;
            default:      rdata = '0;
        endcase
    end

    always_comb begin
        ack_d     = accept & ~access_bad;
        err_d     = accept & access_bad;
        dat_d     = (ack_d & ~s_wb_we_i) ? rdata : '0;
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        mask_d    = mask_q;
        w1c_bits  = '0;
        if (do_write) begin
            case (reg_off)
                REG_SCRATCH:  scratch_d = (scratch_q & ~wmask) | (s_wb_dat_i & wmask);
                REG_CTRL:     ctrl_d    = (ctrl_q & ~wmask) | (s_wb_dat_i & wmask);
                REG_IRQ_MASK: mask_d    = (mask_q & ~wmask) | (s_wb_dat_i & wmask);
                REG_IRQ_PEND: w1c_bits  = s_wb_dat_i[EVENT_W-1:0] & wmask[EVENT_W-1:0];
                default:      ;
            endcase
        end
        // A fresh edge outranks a simultaneous clear of the same bit.
        pend_d   = (pend_q & ~w1c_bits) | event_rise;
        cycle_d  = cycle_q + 32'd1;
        errcnt_d = (err_d && (errcnt_q != 32'hFFFF_FFFF)) ? errcnt_q + 32'd1 : errcnt_q;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            scratch_q <= '0;
            ctrl_q    <= '0;
            mask_q    <= '0;
            pend_q    <= '0;
            cycle_q   <= '0;
            errcnt_q  <= '0;
        end else begin
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            cycle_q   <= cycle_d;
            errcnt_q  <= errcnt_d;
        end
    end

    assign s_wb_ack_o = ack_q;
    assign s_wb_err_o = err_q;
    assign s_wb_dat_o = dat_q;
    assign o_ctrl     = ctrl_q;
    assign o_irq      = |(pend_q & mask_q[EVENT_W-1:0]);

endmodule

// File: tb/tb_wb_reg_slave.sv
// Bench for wb_reg_slave: a transaction-level register model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_wb_reg_slave;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          EW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   adr = '0;
    logic [31:0]   dat_i = '0;
    logic [31:0]   dat_o;
    logic          we = 1'b0;
    logic [3:0]    sel = '0;
    logic          stb = 1'b0;
    logic          cyc = 1'b0;
    logic          ack;
    logic          err;
    logic [31:0]   status = '0;
    logic [EW-1:0] ev = '0;
    logic [31:0]   ctrl;
    logic          irq;

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_on = 1'b0;

    always #5 clk = ~clk;

    wb_reg_slave #(.BASE_ADDR(BASE), .ID_VALUE(32'h5A11_0001), .EVENT_W(EW)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .s_wb_adr_i(adr), .s_wb_dat_i(dat_i), .s_wb_dat_o(dat_o),
        .s_wb_we_i(we), .s_wb_sel_i(sel), .s_wb_stb_i(stb), .s_wb_cyc_i(cyc),
        .s_wb_ack_o(ack), .s_wb_err_o(err),
        .i_status(status), .i_event(ev), .o_ctrl(ctrl), .o_irq(irq)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural register model ----------------
    logic [31:0]   m_scratch = '0, m_ctrl = '0, m_mask = '0, m_cycle = '0, m_errcnt = '0;
    logic [EW-1:0] m_pend = '0;
    logic          m_ack = 1'b0, m_err = 1'b0;
    logic [31:0]   m_dat = '0;
    logic [EW-1:0] ev_h1 = '0, ev_h2 = '0, ev_h3 = '0, ev_h4 = '0;
    logic [31:0]   st_h1 = '0, st_h2 = '0;

    task automatic model_reset();
        m_scratch = '0; m_ctrl = '0; m_mask = '0; m_cycle = '0; m_errcnt = '0;
        m_pend = '0; m_ack = 1'b0; m_err = 1'b0; m_dat = '0;
        ev_h1 = '0; ev_h2 = '0; ev_h3 = '0; ev_h4 = '0;
        st_h1 = '0; st_h2 = '0;
    endtask

    task automatic model_step();
        logic [31:0]   off, m, rd, clr;
        logic          nack, nerr, bad;
        logic [EW-1:0] set;
        set  = ev_h3 & ~ev_h4;   // input rose three edges ago
        nack = 1'b0; nerr = 1'b0; rd = '0; clr = '0;
        if (cyc && stb && !m_ack && !m_err) begin
            off = adr - BASE;
            bad = (off >= 32) || (adr[1:0] != 2'b00) ||
                  (we && (off == 0 || off == 12 || off == 24 || off == 28));
            if (bad) begin
                nerr = 1'b1;
                if (m_errcnt != 32'hFFFF_FFFF) m_errcnt = m_errcnt + 1;
            end else begin
                nack = 1'b1;
                for (int b = 0; b < 4; b++) m[8*b +: 8] = sel[b] ? 8'hFF : 8'h00;
                if (we) begin
                    case (off)
                        4:  m_scratch = (m_scratch & ~m) | (dat_i & m);
                        8:  m_ctrl    = (m_ctrl & ~m) | (dat_i & m);
                        16: clr       = dat_i & m;
                        20: m_mask    = (m_mask & ~m) | (dat_i & m);
                        default: ;
                    endcase
                end else begin
                    case (off)
                        0:  rd = 32'h5A11_0001;
                        4:  rd = m_scratch;
                        8:  rd = m_ctrl;
                        12: rd = st_h2;
                        16: rd = 32'(m_pend);
                        20: rd = m_mask;
                        24: rd = m_cycle;
                        28: rd = m_errcnt;
                        default: rd = '0;
                    endcase
                end
            end
        end
        m_pend  = (m_pend & ~clr[EW-1:0]) | set;
        ev_h4 = ev_h3; ev_h3 = ev_h2; ev_h2 = ev_h1; ev_h1 = ev;
        st_h2 = st_h1; st_h1 = status;
        m_cycle = m_cycle + 1;
        m_ack = nack; m_err = nerr; m_dat = rd;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Per-cycle compare of every DUT output against the model.
    initial forever begin
        @(posedge clk);
        #1;
        check("ack", 32'(ack), 32'(m_ack));
        check("err", 32'(err), 32'(m_err));
        check("dat_o", dat_o, m_dat);
        check("o_ctrl", ctrl, m_ctrl);
        check("o_irq", 32'(irq), 32'(|(m_pend & m_mask[EW-1:0])));
    end

    initial forever begin
        @(posedge clk);
        #3;
        if (rand_on) begin
            if ($urandom_range(0, 3) == 0) ev = EW'($urandom);
            if ($urandom_range(0, 3) == 0) status = $urandom;
        end
    end

    // ---------------- bus access helpers ----------------
    task automatic access(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, output logic got_ack, output logic got_err,
                          output logic [31:0] rd, output logic [31:0] ctrl_at);
        @(posedge clk);
        #2;
        adr = a; we = w; sel = s; dat_i = d; cyc = 1'b1; stb = 1'b1;
        got_ack = 1'b0; got_err = 1'b0; rd = '0; ctrl_at = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ack || err) begin
                got_ack = ack; got_err = err; rd = dat_o; ctrl_at = ctrl;
                break;
            end
        end
        if (!(got_ack || got_err)) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: no response for adr %08h", a);
        end
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    logic        ra, re;
    logic [31:0] rv, rc;

    task automatic rd_expect(input string name, input logic [4:0] off, input logic [31:0] exp);
        access(BASE + 32'(off), 1'b0, 4'h0, 32'h0, ra, re, rv, rc);
        check({name, "_ack"}, 32'(ra), 32'd1);
        check(name, rv, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cv [2];
        int          nc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_ctrl", ctrl, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        #1 rst_n = 1'b1;

        rd_expect("id", 5'h00, 32'h5A11_0001);
        access(BASE + 32'h04, 1'b1, 4'b0101, 32'hDEAD_BEEF, ra, re, rv, rc);
        rd_expect("scratch", 5'h04, 32'h00AD_00EF);

        access(BASE + 32'h08, 1'b1, 4'hF, 32'h0000_00FF, ra, re, rv, rc);
        check("ctrl_in_ack", rc, 32'h0000_00FF);
        access(BASE + 32'h00, 1'b1, 4'hF, 32'h1234_5678, ra, re, rv, rc);
        check("id_wr_err", 32'({ra, re}), 32'b01);
        rd_expect("id_after_wr", 5'h00, 32'h5A11_0001);
        rd_expect("errcnt1", 5'h1C, 32'd1);

        access(BASE + 32'h20, 1'b0, 4'hF, 32'h0, ra, re, rv, rc);
        check("oob_err", 32'({ra, re}), 32'b01);
        access(BASE + 32'h06, 1'b0, 4'hF, 32'h0, ra, re, rv, rc);
        check("misalign_err", 32'({ra, re}), 32'b01);
        rd_expect("errcnt3", 5'h1C, 32'd3);

        access(BASE + 32'h14, 1'b1, 4'hF, 32'h0000_0008, ra, re, rv, rc);
        @(posedge clk); #3 ev[3] = 1'b1;
        @(posedge clk);
        @(posedge clk); #3 ev[3] = 1'b0;
        @(posedge clk); #1 check("irq_k2", 32'(irq), 32'd0);
        @(posedge clk); #1 check("irq_k3", 32'(irq), 32'd1);
        rd_expect("pend_set", 5'h10, 32'h08);

        // Clear of bit 3 lands on the same edge that a new rise sets it.
        @(posedge clk); #3 ev[3] = 1'b1;
        @(posedge clk); #3 ev[3] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        adr = BASE + 32'h10; we = 1'b1; sel = 4'hF; dat_i = 32'h08; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1 check("w1c_race_ack", 32'(ack), 32'd1);
        #1 cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rd_expect("pend_set_wins", 5'h10, 32'h08);
        access(BASE + 32'h10, 1'b1, 4'hF, 32'h08, ra, re, rv, rc);
        rd_expect("pend_clr", 5'h10, 32'h00);
        check("irq_clr", 32'(irq), 32'd0);

        @(posedge clk); #2;
        adr = BASE + 32'h18; we = 1'b0; sel = 4'h0; cyc = 1'b1; stb = 1'b1;
        nc = 0;
        for (int i = 0; i < 8 && nc < 2; i++) begin
            @(posedge clk); #1;
            if (ack) begin cv[nc] = dat_o; nc++; end
        end
        #1 cyc = 1'b0; stb = 1'b0;
        check("cycle_b2b_count", 32'(nc), 32'd2);
        check("cycle_b2b_delta", cv[1] - cv[0], 32'd2);

        @(posedge clk); #2;
        adr = BASE + 32'h08; we = 1'b1; sel = 4'hF; dat_i = 32'h55; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #0.5 rst_n = 1'b0;
        #0.5;
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_dat", dat_o, 32'd0);
        check("rst_mid_ctrl", ctrl, 32'd0);
        #1 cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
        rd_expect("ctrl_after_rst", 5'h08, 32'h0);

        rand_on = 1'b1;
        for (int t = 0; t < 300; t++) begin
            int          k;
            logic [31:0] a;
            k = $urandom_range(0, 11);
            if (k < 8)        a = BASE + 32'(k * 4);
            else if (k == 8)  a = BASE + 32'h20 + 32'($urandom_range(0, 7) * 4);
            else if (k == 9)  a = BASE + 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
            else if (k == 10) a = BASE - 32'd4;
            else              a = $urandom;
            access(a, 1'($urandom), 4'($urandom), $urandom, ra, re, rv, rc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rand_on = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
